ps2_scancode_decoder: RTL
=========================

# ps2_scancode_decoder

Consumes validated set‑2 scan‑code bytes from the PS/2 receive stage and turns them into key events. Tracks prefix sequences (E0, F0, E1), modifier state (shift, ctrl, caps lock) and typematic repeats. Emits one registered event per completed key sequence: scan code, make/break, extended flag and translated ASCII. Sits between the PS/2 receiver and the display/console logic.

## Interface
- No parameters.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active‑high.
- `code_valid` input 1: one‑cycle strobe, a new byte from the receiver.
- `code` input 8: received scan‑code byte, sampled when `code_valid`=1.
- `key_valid` output 1: one‑cycle pulse, event fields valid.
- `key_scan` output 8: final scan byte of the sequence, prefixes stripped.
- `key_ext` output 1: sequence carried an E0 prefix.
- `key_break` output 1: 1 = release (F0 seen), 0 = press.
- `key_repeat` output 1: make of the key already held (typematic).
- `key_ascii` output 8: translated ASCII; 0x00 if no mapping or `key_ext`=1.
- `shift` output 1: left or right shift currently held.
- `ctrl` output 1: left or right ctrl currently held.
- `caps` output 1: caps‑lock toggle state.
- `press_count` output 8: non‑repeat make events, wraps 255→0.

## Operation
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP (E1 pause sequence).
- IDLE: E0→EXT; F0→BRK; E1→SKIP with `skip_cnt`=7; any other byte → emit make event, stay IDLE.
- EXT: F0→EXT_BRK; E0 stays EXT; other byte → emit extended make, →IDLE.
- BRK: any byte → emit break, →IDLE. EXT_BRK: any byte → emit extended break, →IDLE.
- SKIP: each `code_valid` decrements `skip_cnt`; at 0 return to IDLE. No events are produced for the pause sequence.
- Held key: a register `held_scan`/`held_ext`/`held_vld`. A make matching the held key sets `key_repeat`=1. Any other make overwrites the held key. A break of the held key clears `held_vld`.
- `press_count` increments on each make with `key_repeat`=0. Breaks never count.
- Modifiers:
  - Shift is 0x12 (left) and 0x59 (right), non‑extended. Ctrl is 0x14 (left) and E0 14 (right). Each side has its own flag: make sets it, break clears it. Outputs are the OR of both sides.
- Caps: 0x58 make with `key_repeat`=0 toggles `caps`; break ignored.
- ASCII:
  - Keymap gives an unshifted and a shifted value per non‑extended code.
  - Letters: uppercase when `shift` XOR `caps`.
  - Other keys: the shifted value when `shift`=1.
  - Shift for a translation is the state before the current event is applied.
  - Breaks report the same ASCII as their make.
- Unmapped codes still produce an event, with `key_ascii`=0x00.

## Timing
- `key_valid` and all `key_*` fields are registered; they appear the cycle after the `code_valid` that completes a sequence.
- `key_*` fields hold their value until the next event.
- `shift`, `ctrl`, `caps`, `press_count` update in the same cycle as `key_valid`.
- Back‑to‑back `code_valid` on consecutive cycles must be accepted, with no stall.
- Reset takes effect the cycle after `reset`=1, including in the middle of a sequence. Reset values:
  - state IDLE, `skip_cnt` 0, `held_vld` 0;
  - all outputs 0, including `key_*`, `shift`, `ctrl`, `caps` and `press_count`.
- A prefix byte arriving in BRK/EXT_BRK is treated as the final byte (no nesting). E0 in EXT is absorbed.

## Structure
- Package `ps2_pkg`:
  - scan constants (E0, F0, E1, LSHIFT, RSHIFT, CTRL, CAPS);
  - state enum;
  - `PAUSE_SKIP`=7.
- Sub‑module `ps2_keymap`: combinational ROM, 8‑bit code → {is_letter, ascii_lo, ascii_hi}, set‑2 table. Covers:
  - letters, digits, space 0x29, enter 0x5A, backspace 0x66;
  - punctuation `- = [ ] ; ' , . /` and backquote;
  - all others → 0.
- Decoder FSM, modifier and held‑key logic live in the top module.

## Test plan
- Bytes 1C, F0 1C: make {scan 1C, ascii 0x61, break 0, count 1}, then break {ascii 0x61, break 1}; count stays 1.
- Bytes 12, 1C, F0 1C, F0 12: second event ascii 0x41. After F0 12 `shift`=0. Count 2.
- Bytes 58, F0 58, 1C: `caps`=1, ascii 0x41. Then 12, 1C gives 0x61, and 12, 16 gives 0x21 ('!').
- Bytes 1C, 1C, 1C: three events, `key_repeat` 0,1,1; count 1. Then F0 1C, 1C gives `key_repeat`=0, count 2.
- Bytes E0 75, E0 F0 75, E0 14: events {ext 1, scan 75, ascii 0x00}, {ext 1, break 1}; then `ctrl`=1.
- Bytes E1 14 77 E1 F0 14 F0 77, then 1C: no event for the pause sequence, then a make with ascii 0x61. Separately, `reset` asserted after a lone F0 → next 1C is a make, not a break.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 set-2 scan-code decoder.
// Prefix and modifier codes, decoder states and the keymap entry layout.
package ps2_pkg;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Bytes that follow E1 in the Pause/Break make sequence.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } state_t;

    typedef struct packed {
        logic       is_letter;
        logic [7:0] ascii_lo;
        logic [7:0] ascii_hi;
    } keymap_t;

    function automatic logic is_prefix(input logic [7:0] c);
        return (c == SC_E0) || (c == SC_F0) || (c == SC_E1);
    endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Combinational set-2 keymap: scan code to unshifted/shifted ASCII.
// Letters carry lowercase in ascii_lo and uppercase in ascii_hi.
module ps2_keymap
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    output logic       is_letter,
    output logic [7:0] ascii_lo,
    output logic [7:0] ascii_hi
);

    keymap_t entry;

    function automatic keymap_t letter(input logic [7:0] upper);
        keymap_t e;
        e.is_letter = 1'b1;
        e.ascii_lo  = upper | 8'h20;
        e.ascii_hi  = upper;
        return e;
    endfunction

    function automatic keymap_t sym(input logic [7:0] lo, input logic [7:0] hi);
        keymap_t e;
        e.is_letter = 1'b0;
        e.ascii_lo  = lo;
        e.ascii_hi  = hi;
        return e;
    endfunction

    always_comb begin
        entry = '0;
        case (code)
            8'h1C: entry = letter("A");
            8'h32: entry = letter("B");
            8'h21: entry = letter("C");
            8'h23: entry = letter("D");
            8'h24: entry = letter("E");
            8'h2B: entry = letter("F");
            8'h34: entry = letter("G");
            8'h33: entry = letter("H");
            8'h43: entry = letter("I");
            8'h3B: entry = letter("J");
            8'h42: entry = letter("K");
            8'h4B: entry = letter("L");
            8'h3A: entry = letter("M");
            8'h31: entry = letter("N");
            8'h44: entry = letter("O");
            8'h4D: entry = letter("P");
            8'h15: entry = letter("Q");
            8'h2D: entry = letter("R");
            8'h1B: entry = letter("S");
            8'h2C: entry = letter("T");
            8'h3C: entry = letter("U");
            8'h2A: entry = letter("V");
            8'h1D: entry = letter("W");
            8'h22: entry = letter("X");
            8'h35: entry = letter("Y");
            8'h1A: entry = letter("Z");
            8'h16: entry = sym("1", "!");
            8'h1E: entry = sym("2", "@");
            8'h26: entry = sym("3", "#");
            8'h25: entry = sym("4", "$");
            8'h2E: entry = sym("5", "%");
            8'h36: entry = sym("6", "^");
            8'h3D: entry = sym("7", "&");
            8'h3E: entry = sym("8", "*");
            8'h46: entry = sym("9", "(");
            8'h45: entry = sym("0", ")");
            8'h29: entry = sym(8'h20, 8'h20);
            8'h5A: entry = sym(8'h0D, 8'h0D);
            8'h66: entry = sym(8'h08, 8'h08);
            8'h4E: entry = sym("-", "_");
            8'h55: entry = sym("=", "+");
            8'h54: entry = sym("[", "{");
            8'h5B: entry = sym("]", "}");
            8'h4C: entry = sym(";", ":");
            8'h52: entry = sym("'", 8'h22);
            8'h41: entry = sym(",", "<");
            8'h49: entry = sym(".", ">");
            8'h4A: entry = sym("/", "?");
            8'h0E: entry = sym(8'h60, "~");
            default: entry = '0;
        endcase
    end

    assign is_letter = entry.is_letter;
    assign ascii_lo  = entry.ascii_lo;
    assign ascii_hi  = entry.ascii_hi;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Turns validated set-2 scan-code bytes into registered key events, tracking
// prefixes, modifiers, caps lock, the held key for typematic repeat and a press count.
module ps2_scancode_decoder
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       code_valid,
    input  logic [7:0] code,
    output logic       key_valid,
    output logic [7:0] key_scan,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_repeat,
    output logic [7:0] key_ascii,
    output logic       shift,
    output logic       ctrl,
    output logic       caps,
    output logic [7:0] press_count
);

    state_t     state_q, state_d;
    logic [2:0] skip_cnt_q, skip_cnt_d;

    logic ev_emit, ev_ext, ev_break;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            skip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        if (code_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (code == SC_E0) begin
                        state_d = ST_EXT;
                    end else if (code == SC_F0) begin
                        state_d = ST_BRK;
                    end else if (code == SC_E1) begin
                        state_d    = ST_SKIP;
                        skip_cnt_d = PAUSE_SKIP;
                    end
                end
                ST_EXT: begin
                    if (code == SC_F0) begin
                        state_d = ST_EXT_BRK;
                    end else if (code != SC_E0) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: state_d = ST_IDLE;
                ST_SKIP: begin
                    if (skip_cnt_q <= 3'd1) begin
                        skip_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        skip_cnt_d = skip_cnt_q - 3'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A prefix in BRK/EXT_BRK is taken as the final byte; no nesting.
    always_comb begin
        ev_emit  = 1'b0;
        ev_ext   = 1'b0;
        ev_break = 1'b0;
        if (code_valid) begin
            case (state_q)
                ST_IDLE: ev_emit = !is_prefix(code);
                ST_EXT: begin
                    ev_emit = (code != SC_F0) && (code != SC_E0);
                    ev_ext  = 1'b1;
                end
                ST_BRK: begin
                    ev_emit  = 1'b1;
                    ev_break = 1'b1;
                end
                ST_EXT_BRK: begin
                    ev_emit  = 1'b1;
                    ev_ext   = 1'b1;
                    ev_break = 1'b1;
                end
                default: ev_emit = 1'b0;
            endcase
        end
    end

    logic       km_letter;
    logic [7:0] km_lo, km_hi;

    ps2_keymap u_keymap (
        .code      (code),
        .is_letter (km_letter),
        .ascii_lo  (km_lo),
        .ascii_hi  (km_hi)
    );

    logic       held_vld_q, held_vld_d;
    logic [7:0] held_scan_q, held_scan_d;
    logic       held_ext_q, held_ext_d;
    logic       lshift_q, lshift_d, rshift_q, rshift_d;
    logic       lctrl_q, lctrl_d, rctrl_q, rctrl_d;
    logic       caps_q, caps_d;
    logic [7:0] count_q, count_d;
    logic       key_valid_q, key_valid_d;
    logic [7:0] key_scan_q, key_scan_d;
    logic       key_ext_q, key_ext_d;
    logic       key_break_q, key_break_d;
    logic       key_repeat_q, key_repeat_d;
    logic [7:0] key_ascii_q, key_ascii_d;

    logic       is_make, is_brk, held_match, rep, shift_cur;
    logic [7:0] ascii_ev;

    assign is_make    = ev_emit && !ev_break;
    assign is_brk     = ev_emit && ev_break;
    assign held_match = held_vld_q && (held_scan_q == code) && (held_ext_q == ev_ext);
    assign rep        = is_make && held_match;
    assign shift_cur  = lshift_q || rshift_q;

    // Translation uses modifier state from before this event is applied.
    always_comb begin
        ascii_ev = 8'h00;
        if (!ev_ext) begin
            if (km_letter) begin
                ascii_ev = (shift_cur ^ caps_q) ? km_hi : km_lo;
            end else begin
                ascii_ev = shift_cur ? km_hi : km_lo;
            end
        end
    end

    always_comb begin
        held_vld_d   = held_vld_q;
        held_scan_d  = held_scan_q;
        held_ext_d   = held_ext_q;
        lshift_d     = lshift_q;
        rshift_d     = rshift_q;
        lctrl_d      = lctrl_q;
        rctrl_d      = rctrl_q;
        caps_d       = caps_q;
        count_d      = count_q;
        key_valid_d  = ev_emit;
        key_scan_d   = key_scan_q;
        key_ext_d    = key_ext_q;
        key_break_d  = key_break_q;
        key_repeat_d = key_repeat_q;
        key_ascii_d  = key_ascii_q;

        if (ev_emit) begin
            key_scan_d   = code;
            key_ext_d    = ev_ext;
            key_break_d  = ev_break;
            key_repeat_d = rep;
            key_ascii_d  = ascii_ev;

            if (!ev_ext && code == SC_LSHIFT) lshift_d = !ev_break;
            if (!ev_ext && code == SC_RSHIFT) rshift_d = !ev_break;
            if (!ev_ext && code == SC_CTRL)   lctrl_d  = !ev_break;
            if (ev_ext && code == SC_CTRL)    rctrl_d  = !ev_break;
        end

        if (is_make) begin
            held_vld_d  = 1'b1;
            held_scan_d = code;
            held_ext_d  = ev_ext;
            if (!rep) begin
                count_d = count_q + 8'd1;
                if (!ev_ext && code == SC_CAPS) caps_d = !caps_q;
            end
        end else if (is_brk && held_match) begin
            held_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            held_vld_q   <= 1'b0;
            held_scan_q  <= '0;
            held_ext_q   <= 1'b0;
            lshift_q     <= 1'b0;
            rshift_q     <= 1'b0;
            lctrl_q      <= 1'b0;
            rctrl_q      <= 1'b0;
            caps_q       <= 1'b0;
            count_q      <= '0;
            key_valid_q  <= 1'b0;
            key_scan_q   <= '0;
            key_ext_q    <= 1'b0;
            key_break_q  <= 1'b0;
            key_repeat_q <= 1'b0;
            key_ascii_q  <= '0;
        end else begin
            held_vld_q   <= held_vld_d;
            held_scan_q  <= held_scan_d;
            held_ext_q   <= held_ext_d;
            lshift_q     <= lshift_d;
            rshift_q     <= rshift_d;
            lctrl_q      <= lctrl_d;
            rctrl_q      <= rctrl_d;
            caps_q       <= caps_d;
            count_q      <= count_d;
            key_valid_q  <= key_valid_d;
            key_scan_q   <= key_scan_d;
            key_ext_q    <= key_ext_d;
            key_break_q  <= key_break_d;
            key_repeat_q <= key_repeat_d;
            key_ascii_q  <= key_ascii_d;
        end
    end

    assign key_valid   = key_valid_q;
    assign key_scan    = key_scan_q;
    assign key_ext     = key_ext_q;
    assign key_break   = key_break_q;
    assign key_repeat  = key_repeat_q;
    assign key_ascii   = key_ascii_q;
    assign shift       = lshift_q || rshift_q;
    assign ctrl        = lctrl_q || rctrl_q;
    assign caps        = caps_q;
    assign press_count = count_q;

endmodule
